// File: rtl/n64_sdram_arbiter.sv
// Single-owner arbiter sharing the SDRAM sequencer port between N64 and DMA.
// N64 has priority; a starvation counter forces a DMA grant after a run of N64 grants.
module n64_sdram_arbiter #(
  parameter int ADDR_W           = 26,
  parameter int DATA_W           = 16,
  parameter int DMA_STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n64_request,
  input  logic              n64_write,
  input  logic [ADDR_W-1:0] n64_address,
  input  logic [DATA_W-1:0] n64_wdata,
  output logic              n64_ack,
  output logic [DATA_W-1:0] n64_rdata,
  input  logic              dma_request,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_request,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LIMIT = 4'(DMA_STARVE_LIMIT);

  state_t            state, state_n;
  logic [3:0]        starve, starve_n;
  logic              pick_n64, pick_dma;
  logic              mem_request_n, mem_write_n, owner_n;
  logic [ADDR_W-1:0] mem_address_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              n64_ack_n, dma_ack_n;
  logic [DATA_W-1:0] n64_rdata_n, dma_rdata_n;

  always_comb begin
    state_n       = state;
    starve_n      = starve;
    mem_request_n = mem_request;
    mem_write_n   = mem_write;
    mem_address_n = mem_address;
    mem_wdata_n   = mem_wdata;
    owner_n       = owner;
    n64_ack_n     = 1'b0;
    dma_ack_n     = 1'b0;
    n64_rdata_n   = n64_rdata;
    dma_rdata_n   = dma_rdata;
    // N64 yields only when DMA has waited through LIMIT grants
    pick_n64 = n64_request && !(dma_request && starve == LIMIT);
    pick_dma = !pick_n64 && dma_request;

    unique case (state)
      IDLE: begin
        if (pick_n64) begin
          mem_request_n = 1'b1;
          mem_write_n   = n64_write;
          mem_address_n = n64_address;
          mem_wdata_n   = n64_wdata;
          owner_n       = 1'b0;
          state_n       = ACCESS;
          if (!dma_request)
            starve_n = 4'd0;
          else if (starve >= LIMIT)
            starve_n = LIMIT;
          else
            starve_n = starve + 4'd1;
        end else if (pick_dma) begin
          mem_request_n = 1'b1;
          mem_write_n   = dma_write;
          mem_address_n = dma_address;
          mem_wdata_n   = dma_wdata;
          owner_n       = 1'b1;
          starve_n      = 4'd0;
          state_n       = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_request_n = 1'b0;
          state_n       = DONE;
          if (owner) begin
            dma_ack_n   = 1'b1;
            dma_rdata_n = mem_rdata;
          end else begin
            n64_ack_n   = 1'b1;
            n64_rdata_n = mem_rdata;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      starve      <= 4'd0;
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      owner       <= 1'b0;
      n64_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      n64_rdata   <= '0;
      dma_rdata   <= '0;
    end else begin
      state       <= state_n;
      starve      <= starve_n;
      mem_request <= mem_request_n;
      mem_write   <= mem_write_n;
      mem_address <= mem_address_n;
      mem_wdata   <= mem_wdata_n;
      owner       <= owner_n;
      n64_ack     <= n64_ack_n;
      dma_ack     <= dma_ack_n;
      n64_rdata   <= n64_rdata_n;
      dma_rdata   <= dma_rdata_n;
    end
  end

endmodule

// File: tb/tb_n64_sdram_arbiter.sv
// Bench for n64_sdram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level grant/starvation model.
module tb_n64_sdram_arbiter;
  localparam int AW  = 26;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          n64_request = 0, n64_write = 0;
  logic [AW-1:0] n64_address = '0;
  logic [DW-1:0] n64_wdata = '0;
  logic          n64_ack;
  logic [DW-1:0] n64_rdata;
  logic          dma_request = 0, dma_write = 0;
  logic [AW-1:0] dma_address = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_request, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic          owner;

  int tests = 0;
  int fails = 0;

  n64_sdram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DMA_STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .n64_request(n64_request), .n64_write(n64_write),
    .n64_address(n64_address), .n64_wdata(n64_wdata),
    .n64_ack(n64_ack), .n64_rdata(n64_rdata),
    .dma_request(dma_request), .dma_write(dma_write),
    .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Observations from the last served transaction
  logic          cap_ok, cap_unstable;
  int            cap_wait;
  logic          cap_write, cap_owner;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_nack, cap_dack, cap_memreq1;
  logic [DW-1:0] cap_nrd, cap_drd;
  logic          cap_nack2, cap_dack2, cap_memreq2;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic raise_n64();
    n64_request = 1'b1;
    n64_write   = 1'($urandom);
    n64_address = AW'($urandom);
    n64_wdata   = DW'($urandom);
  endtask

  task automatic raise_dma();
    dma_request = 1'b1;
    dma_write   = 1'($urandom);
    dma_address = AW'($urandom);
    dma_wdata   = DW'($urandom);
  endtask

  // Acts as the sequencer for one transaction and as the requesters' ack handling.
  task automatic serve(input int dly, input logic [DW-1:0] rd, input bit mutate);
    cap_ok = 1'b0;
    cap_unstable = 1'b0;
    cap_wait = 0;
    while (!mem_request && cap_wait < 50) begin
      tick();
      cap_wait++;
    end
    if (!mem_request) return;
    cap_ok    = 1'b1;
    cap_addr  = mem_address;
    cap_write = mem_write;
    cap_wdata = mem_wdata;
    cap_owner = owner;
    for (int i = 0; i < dly; i++) begin
      if (mutate) begin
        n64_address = AW'($urandom);
        n64_wdata   = DW'($urandom);
      end
      tick();
      if (!mem_request || mem_address !== cap_addr ||
          mem_write !== cap_write || mem_wdata !== cap_wdata)
        cap_unstable = 1'b1;
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = DW'($urandom);
    cap_nack    = n64_ack;
    cap_dack    = dma_ack;
    cap_nrd     = n64_rdata;
    cap_drd     = dma_rdata;
    cap_memreq1 = mem_request;
    if (n64_ack) n64_request = 1'b0;
    if (dma_ack) dma_request = 1'b0;
    tick();
    cap_nack2   = n64_ack;
    cap_dack2   = dma_ack;
    cap_memreq2 = mem_request;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({mem_request, mem_write, mem_address, mem_wdata, n64_ack, dma_ack,
         n64_rdata, dma_rdata, owner} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got req=%b addr=%h owner=%b exp all zero",
               mem_request, mem_address, owner);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_n64_read();
    n64_write   = 1'b0;
    n64_address = 26'h0001000;
    n64_wdata   = 16'h0;
    n64_request = 1'b1;
    serve(3, 16'hBEEF, 0);
    tests++;
    if (!cap_ok || cap_wait != 1) begin
      fails++;
      $display("FAIL n64_grant_latency got ok=%b wait=%0d exp ok=1 wait=1", cap_ok, cap_wait);
    end
    tests++;
    if ({cap_addr, cap_write, cap_owner, cap_unstable} !== {26'h0001000, 3'b000}) begin
      fails++;
      $display("FAIL n64_read_fields got addr=%h w=%b own=%b unst=%b exp addr=0001000 w=0 own=0 unst=0",
               cap_addr, cap_write, cap_owner, cap_unstable);
    end
    tests++;
    if ({cap_nack, cap_dack, cap_memreq1, cap_nrd} !== {3'b100, 16'hBEEF}) begin
      fails++;
      $display("FAIL n64_read_ack got nack=%b dack=%b mreq=%b rd=%h exp 1 0 0 beef",
               cap_nack, cap_dack, cap_memreq1, cap_nrd);
    end
    tests++;
    if ({cap_nack2, cap_dack2, cap_memreq2} !== 3'b000) begin
      fails++;
      $display("FAIL n64_ack_pulse got nack=%b dack=%b mreq=%b exp 000",
               cap_nack2, cap_dack2, cap_memreq2);
    end
  endtask

  task automatic test_dma_write();
    dma_write   = 1'b1;
    dma_address = 26'h3FFFFFE;
    dma_wdata   = 16'h1234;
    dma_request = 1'b1;
    serve(2, 16'h7777, 0);
    tests++;
    if ({cap_ok, cap_owner, cap_write, cap_addr, cap_wdata} !==
        {3'b111, 26'h3FFFFFE, 16'h1234}) begin
      fails++;
      $display("FAIL dma_write_fields got own=%b w=%b addr=%h wd=%h exp 1 1 3fffffe 1234",
               cap_owner, cap_write, cap_addr, cap_wdata);
    end
    tests++;
    if ({cap_dack, cap_nack, cap_dack2, cap_nrd} !== {3'b100, 16'hBEEF}) begin
      fails++;
      $display("FAIL dma_write_ack got dack=%b nack=%b dack2=%b nrd=%h exp 1 0 0 beef",
               cap_dack, cap_nack, cap_dack2, cap_nrd);
    end
  endtask

  task automatic test_simultaneous();
    logic o1, o2;
    int w2;
    raise_n64();
    raise_dma();
    serve(1, 16'h1111, 0);
    o1 = cap_owner;
    serve(1, 16'h2222, 0);
    o2 = cap_owner;
    w2 = cap_wait;
    tests++;
    if ({o1, o2} !== 2'b01 || w2 != 1) begin
      fails++;
      $display("FAIL simultaneous_order got %b%b wait=%0d exp 01 wait=1", o1, o2, w2);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] order;
    logic       late;
    late = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!n64_request) raise_n64();
      if (!dma_request) raise_dma();
      serve(int'($urandom_range(0, 2)), DW'($urandom), 0);
      order[i] = cap_owner;
      if (!cap_ok || cap_wait != 1) late = 1'b1;
    end
    tests++;
    if (order !== 10'b1000010000 || late) begin
      fails++;
      $display("FAIL starve_order got %b late=%b exp 1000010000 late=0", order, late);
    end
    serve(0, DW'($urandom), 0);
    tests++;
    if (cap_owner !== 1'b0 || cap_nack !== 1'b1) begin
      fails++;
      $display("FAIL starve_tail got own=%b nack=%b exp 0 1", cap_owner, cap_nack);
    end
  endtask

  task automatic test_ignore_changes();
    logic bad;
    n64_write   = 1'b1;
    n64_address = 26'h2A5A5A5;
    n64_wdata   = 16'hCAFE;
    n64_request = 1'b1;
    serve(4, 16'h4321, 1);
    tests++;
    if ({cap_addr, cap_wdata, cap_write, cap_unstable} !== {26'h2A5A5A5, 16'hCAFE, 2'b10}) begin
      fails++;
      $display("FAIL latched_fields got addr=%h wd=%h w=%b unst=%b exp 2a5a5a5 cafe 1 0",
               cap_addr, cap_wdata, cap_write, cap_unstable);
    end
    bad = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    if (n64_ack || dma_ack || mem_request) bad = 1'b1;
    tick();
    if (n64_ack || dma_ack || mem_request) bad = 1'b1;
    tests++;
    if (bad || mem_address !== 26'h2A5A5A5 || mem_wdata !== 16'hCAFE ||
        n64_rdata !== 16'h4321) begin
      fails++;
      $display("FAIL spurious_ack got bad=%b addr=%h wd=%h nrd=%h exp 0 2a5a5a5 cafe 4321",
               bad, mem_address, mem_wdata, n64_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [2:0] own3;
    for (int i = 0; i < 3; i++) begin
      if (!n64_request) raise_n64();
      if (!dma_request) raise_dma();
      serve(1, DW'($urandom), 0);
      own3[i] = cap_owner;
    end
    tests++;
    if (own3 !== 3'b000) begin
      fails++;
      $display("FAIL pre_reset_grants got %b exp 000", own3);
    end
    raise_n64();
    tick();
    tests++;
    if (mem_request !== 1'b1 || owner !== 1'b0 || mem_address !== n64_address) begin
      fails++;
      $display("FAIL fourth_n64_grant got req=%b own=%b addr=%h exp 1 0 %h",
               mem_request, owner, mem_address, n64_address);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({mem_request, mem_write, mem_address, mem_wdata, n64_ack, dma_ack,
         n64_rdata, dma_rdata, owner} !== '0) begin
      fails++;
      $display("FAIL async_reset got req=%b addr=%h nrd=%h own=%b exp all zero",
               mem_request, mem_address, n64_rdata, owner);
    end
    tick();
    reset = 1'b0;
    serve(1, 16'hC0DE, 0);
    tests++;
    if ({cap_ok, cap_owner, cap_nack, cap_nrd, cap_drd} !== {3'b101, 16'hC0DE, 16'h0}) begin
      fails++;
      $display("FAIL fresh_starve got ok=%b own=%b nack=%b nrd=%h drd=%h exp 1 0 1 c0de 0000",
               cap_ok, cap_owner, cap_nack, cap_nrd, cap_drd);
    end
    serve(1, 16'hD00D, 0);
    tests++;
    if ({cap_owner, cap_dack, cap_drd} !== {2'b11, 16'hD00D}) begin
      fails++;
      $display("FAIL post_reset_dma got own=%b dack=%b drd=%h exp 1 1 d00d",
               cap_owner, cap_dack, cap_drd);
    end
  endtask

  task automatic test_random();
    int            starve_m;
    logic [DW-1:0] last_n, last_d, rd;
    logic          win, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    starve_m = 0;
    last_n = 16'hC0DE;
    last_d = 16'hD00D;
    for (int t = 0; t < 80; t++) begin
      if (!n64_request && $urandom_range(0, 2) != 0) raise_n64();
      if (!dma_request && $urandom_range(0, 2) != 0) raise_dma();
      if (!n64_request && !dma_request) raise_dma();
      if (n64_request && !(dma_request && starve_m >= LIM)) begin
        win = 1'b0;
        {ew, ea, ed} = {n64_write, n64_address, n64_wdata};
        starve_m = dma_request ? ((starve_m + 1 > LIM) ? LIM : starve_m + 1) : 0;
      end else begin
        win = 1'b1;
        {ew, ea, ed} = {dma_write, dma_address, dma_wdata};
        starve_m = 0;
      end
      rd = DW'($urandom);
      serve(int'($urandom_range(0, 4)), rd, 0);
      tests++;
      if (!cap_ok || cap_wait != 1 || cap_owner !== win ||
          {cap_write, cap_addr, cap_wdata} !== {ew, ea, ed}) begin
        fails++;
        $display("FAIL rand_grant[%0d] got wait=%0d own=%b f=%h exp wait=1 own=%b f=%h",
                 t, cap_wait, cap_owner, {cap_write, cap_addr, cap_wdata}, win, {ew, ea, ed});
      end
      if (win) last_d = rd;
      else last_n = rd;
      tests++;
      if ({cap_nack, cap_dack, cap_nrd, cap_drd, cap_nack2, cap_dack2, cap_unstable} !==
          {~win, win, last_n, last_d, 3'b000}) begin
        fails++;
        $display("FAIL rand_ack[%0d] got na=%b da=%b nrd=%h drd=%h exp na=%b da=%b nrd=%h drd=%h",
                 t, cap_nack, cap_dack, cap_nrd, cap_drd, ~win, win, last_n, last_d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_n64_read();
    test_dma_write();
    test_simultaneous();
    test_starvation();
    test_ignore_changes();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n64_sdram_arbiter.md
Name: n64_sdram_arbiter

Overview:
- Single-owner arbiter sharing the SDRAM controller command port between the N64 PI bus path and the DMA engine.
- Sits between n64_sdram's two requesters and its memory sequencer. Exactly one transaction is in flight at any time.
- N64 accesses have priority because they are latency-critical. A starvation counter guarantees DMA forward progress.

Parameters:
- ADDR_W, 26, byte address width (64 MiB SDRAM).
- DATA_W, 16, data word width.
- DMA_STARVE_LIMIT, 4, consecutive N64 grants allowed while DMA is pending before DMA is forced; range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- n64_request  input  1  N64 access request, held until n64_ack
- n64_write  input  1  1=write, 0=read; stable while requesting
- n64_address  input  ADDR_W  N64 access address
- n64_wdata  input  DATA_W  N64 write data
- n64_ack  output  1  one-cycle completion pulse to N64
- n64_rdata  output  DATA_W  read data, valid while n64_ack=1
- dma_request / dma_write / dma_address / dma_wdata  input  1/1/ADDR_W/DATA_W  same rules as N64 side
- dma_ack  output  1  one-cycle completion pulse to DMA
- dma_rdata  output  DATA_W  read data, valid while dma_ack=1
- mem_request  output  1  request to SDRAM sequencer, held until mem_ack
- mem_write  output  1  latched direction
- mem_address  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched write data
- mem_ack  input  1  one-cycle completion from sequencer
- mem_rdata  input  DATA_W  read data, valid with mem_ack
- owner  output  1  current/last grant: 0=N64, 1=DMA

Behaviour:
- Reset (async, active-high):
  - State=IDLE, starve counter=0.
  - All outputs 0 (mem_*, n64_ack, dma_ack, rdata buses, owner).
  - An in-flight transaction is abandoned; the sequencer shares the same reset.
- FSM states IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Select the winner.
  - Register its write/address/wdata into mem_write/mem_address/mem_wdata.
  - mem_request<=1, owner<=winner, go to ACCESS.
- Winner selection:
  - N64 if n64_request && !(dma_request && starve==DMA_STARVE_LIMIT).
  - Otherwise DMA if dma_request.
- Starve counter (4 bit):
  - N64 grant with dma_request=1: counter+1, saturating at DMA_STARVE_LIMIT.
  - N64 grant with dma_request=0: counter=0.
  - DMA grant: counter=0.
- ACCESS:
  - mem_request and latched fields held stable until mem_ack.
  - On mem_ack: mem_request<=0; owner's ack<=1; owner's rdata<=mem_rdata; go to DONE.
  - Requester-side changes during ACCESS are ignored; fields are latched.
- DONE:
  - Ack is high for exactly this one cycle. Go to IDLE.
  - The requester must deassert request on the edge where it samples ack=1.
  - A same-side request seen in the following IDLE is treated as a new transaction.
- mem_ack in IDLE or DONE: ignored, no ack generated.
- Non-owner rdata: holds its last value; the non-owner ack stays 0.
- Latency:
  - Request seen in IDLE at cycle 0 -> mem_request=1 at cycle 1.
  - mem_ack at cycle k -> requester ack at k+1 (registered), IDLE at k+2.
  - Earliest next mem_request at k+3.
- Simultaneous requests in IDLE: N64 wins unless the starve limit has been reached.

Test Plan:
- N64 read alone: n64_address=0x0001000, sequencer acks 3 cycles after mem_request with mem_rdata=0xBEEF -> mem_address=0x0001000, mem_write=0; n64_ack single pulse with n64_rdata=0xBEEF; dma_ack stays 0.
- DMA write alone: dma_address=0x3FFFFFE, dma_wdata=0x1234 -> mem_write=1, mem_wdata=0x1234, owner=1; dma_ack one cycle after mem_ack.
- Simultaneous requests, counter=0 -> N64 granted first, DMA granted immediately after the N64 DONE/IDLE cycle.
- Continuous N64 requests plus a pending DMA request, limit=4 -> grant order N,N,N,N,D,N...; counter returns to 0 after the DMA grant.
- Requester changes n64_address and n64_wdata mid-ACCESS; sequencer sends a spurious mem_ack in IDLE -> mem_* fields unchanged; no ack on either side.
- reset asserted during ACCESS -> all outputs 0 asynchronously; after release, first request is granted with a fresh starve count.
